e203_icb_mem_slave: RTL and testbench
=====================================

Name: e203_icb_mem_slave

Overview:
- ICB slave memory model that sits directly on the core's memory-side ICB ports (ppi/clint/plic/fio, any one instance per port).
- Answers each command with a response carrying read data and an error flag, so formal and simulation harnesses around the e203 core have a well-behaved backing store.
- Supports programmable response latency, bounded outstanding commands and response back-pressure.

Parameters:
- AW, 32, ICB address width
- DW, 32, ICB data width; wmask is DW/8 bits
- MEM_AW, 10, log2 of memory depth in words (1024 x 32-bit words)
- BASE_ADDR, 32'h1000_0000, byte base address of the window; must be aligned to (1 << (MEM_AW+2))
- LAT, 1, cycles from command acceptance to response entering the response FIFO; legal range 1..4
- RSP_DEPTH, 2, response FIFO depth; legal range 1..8; also the maximum number of outstanding commands

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accept
- icb_cmd_addr  in  AW  byte address
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_wdata  in  DW  write data
- icb_cmd_wmask  in  DW/8  byte write enables
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response accept
- icb_rsp_err  out  1  response error
- icb_rsp_rdata  out  DW  read data (0 for writes and for errors)

Behaviour:
- Reset: icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0, latency pipe empty, FIFO empty, outstanding count=0.
  - icb_cmd_ready=1 after reset (combinational from count).
  - Memory contents are not reset.
- Handshakes:
  - Accept = icb_cmd_valid & icb_cmd_ready.
  - Response transfer = icb_rsp_valid & icb_rsp_ready.
- Outstanding counter:
  - Range 0..RSP_DEPTH; +1 on accept, -1 on response transfer, unchanged when both occur in the same cycle.
  - icb_cmd_ready = (count < RSP_DEPTH); it depends only on the registered count, with no combinational path from icb_rsp_ready.
- Decode: in-window when addr[AW-1:MEM_AW+2] == BASE_ADDR[AW-1:MEM_AW+2]. Error when out of window or addr[1:0] != 0.
- Read, no error: at accept, the word at addr[MEM_AW+1:2] is captured. Read-before-write ordering holds against older writes, since writes commit at accept.
- Write, no error: at accept, each byte lane i with wmask[i]=1 is updated. wmask=0 is legal, performs no write and gives err=0.
- Error access: no memory update; response has err=1, rdata=0.
- Latency: a LAT-stage shift pipe carries {err, rdata}. An entry accepted at cycle T enters the FIFO at T+LAT and is visible on icb_rsp_* at T+LAT when the FIFO was empty. Minimum cmd-to-rsp latency is LAT.
- FIFO ordering: strict in order. icb_rsp_valid = FIFO non-empty; outputs come from the FIFO head and stay stable while valid & !ready.
- The FIFO cannot overflow: the outstanding counter bounds pipe plus FIFO occupancy to RSP_DEPTH.
- Simultaneous events: a FIFO push and pop in the same cycle keeps occupancy unchanged. With LAT=1 and an empty FIFO, a new response appears the cycle after the previous transfer, with no bubble beyond LAT.
- Back-to-back: with RSP_DEPTH >= LAT+1 and icb_rsp_ready held high, one command is accepted per cycle.
- Reset mid-operation: asserting rst_n=0 drops all in-flight and queued responses immediately (asynchronously). Writes already accepted remain in memory.

Decomposition:
- Package e203_icb_mem_pkg:
  - typedef rsp_entry_t {logic err; logic [DW-1:0] rdata;}
  - function addr_in_window()
  - localparams for the legal LAT / RSP_DEPTH bounds, enforced by elaboration-time assertions
- Sub-module e203_icb_rsp_fifo:
  - synchronous FIFO of rsp_entry_t, parameter DEPTH
  - ports clk, rst_n, push, din, pop, dout, empty, full
  - pointers wrap modulo DEPTH (non-power-of-2 supported); full/empty from a count register
- Top level holds the memory array, decode, latency pipe and outstanding counter.

Test Plan:
- Write 0xDEADBEEF with wmask=4'hF to 0x1000_0010, then read it back -> write rsp err=0 rdata=0; read rsp rdata=0xDEADBEEF at exactly LAT cycles after accept.
- Partial write wmask=4'b0101 with wdata 0x11223344 over 0xFFFFFFFF, then read -> rdata=0xFF22FF44.
- Read from 0x2000_0000 and from 0x1000_0002 -> both return err=1, rdata=0; memory unchanged (verified by a later good read).
- RSP_DEPTH=2, icb_rsp_ready=0, 3 commands offered back-to-back -> 2 accepted, icb_cmd_ready=0 on the third. Raise ready -> responses drain in order, third command accepted the cycle after the first transfer.
- icb_rsp_ready=1 throughout, LAT=1, RSP_DEPTH=2, 16 sequential reads -> one accept per cycle, 16 responses in order, no bubbles.
- Assert rst_n low with 2 responses queued -> icb_rsp_valid=0 immediately. After release, icb_cmd_ready=1 and earlier written data is still readable.

Source files
------------

// File: rtl/e203_icb_mem_pkg.sv
// Shared types, bounds and address decode helper for the e203 ICB memory slave.
// Included by both the response FIFO and the top level.
package e203_icb_mem_pkg;

    localparam int ICB_AW = 32;
    localparam int ICB_DW = 32;

    localparam int LAT_MIN       = 1;
    localparam int LAT_MAX       = 4;
    localparam int RSP_DEPTH_MIN = 1;
    localparam int RSP_DEPTH_MAX = 8;

    typedef struct packed {
        logic              err;
        logic [ICB_DW-1:0] rdata;
    } rsp_entry_t;

    // Window hit: every bit above the word-index field matches the base.
    function automatic logic addr_in_window(input logic [ICB_AW-1:0] addr,
                                            input logic [ICB_AW-1:0] base,
                                            input int unsigned       mem_aw);
        return (addr >> (mem_aw + 2)) == (base >> (mem_aw + 2));
    endfunction

endpackage

// File: rtl/e203_icb_rsp_fifo.sv
// In-order response FIFO; pointers wrap modulo DEPTH, so any depth works,
// and full/empty come from an occupancy count.
module e203_icb_rsp_fifo
    import e203_icb_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  rsp_entry_t din,
    input  logic       pop,
    output rsp_entry_t dout,
    output logic       empty,
    output logic       full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    rsp_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/e203_icb_mem_slave.sv
// ICB slave backing store: memory array, window decode, response latency pipe
// and an outstanding-command counter that bounds pipe plus FIFO occupancy.
module e203_icb_mem_slave
    import e203_icb_mem_pkg::*;
#(
    parameter int          AW        = 32,
    parameter int          DW        = 32,
    parameter int          MEM_AW    = 10,
    parameter logic [AW-1:0] BASE_ADDR = 32'h1000_0000,
    parameter int          LAT       = 1,
    parameter int          RSP_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          icb_cmd_valid,
    output logic          icb_cmd_ready,
    input  logic [AW-1:0] icb_cmd_addr,
    input  logic          icb_cmd_read,
    input  logic [DW-1:0] icb_cmd_wdata,
    input  logic [DW/8-1:0] icb_cmd_wmask,
    output logic          icb_rsp_valid,
    input  logic          icb_rsp_ready,
    output logic          icb_rsp_err,
    output logic [DW-1:0] icb_rsp_rdata
);

    if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
        $error("e203_icb_mem_slave: LAT out of range");
    end
    if (RSP_DEPTH < RSP_DEPTH_MIN || RSP_DEPTH > RSP_DEPTH_MAX) begin : g_bad_depth
        $error("e203_icb_mem_slave: RSP_DEPTH out of range");
    end
    if (AW != ICB_AW || DW != ICB_DW) begin : g_bad_width
        $error("e203_icb_mem_slave: AW/DW must match the package widths");
    end
    if (BASE_ADDR[MEM_AW+1:0] != '0) begin : g_bad_base
        $error("e203_icb_mem_slave: BASE_ADDR not aligned to the window size");
    end

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int NB = DW / 8;

    logic              accept;
    logic              rsp_xfer;
    logic [CW-1:0]     out_cnt_q, out_cnt_d;
    logic [MEM_AW-1:0] word_idx;
    logic              cmd_err;
    rsp_entry_t        cmd_entry;
    rsp_entry_t        fifo_din;
    rsp_entry_t        fifo_dout;
    logic              fifo_push;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DW-1:0]     mem_q [2**MEM_AW];

    assign accept        = icb_cmd_valid & icb_cmd_ready;
    assign rsp_xfer      = icb_rsp_valid & icb_rsp_ready;
    assign icb_cmd_ready = (out_cnt_q < CW'(RSP_DEPTH));
    assign word_idx      = icb_cmd_addr[MEM_AW+1:2];
    assign cmd_err       = !addr_in_window(icb_cmd_addr, BASE_ADDR, MEM_AW)
                           || (icb_cmd_addr[1:0] != 2'b00);

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({accept, rsp_xfer})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_cnt_q <= '0;
        else        out_cnt_q <= out_cnt_d;
    end

    // Reads sample the array before this cycle's write could land, and only one
    // command is accepted per cycle, so reads always see all older writes.
    always_comb begin
        cmd_entry.err   = cmd_err;
        cmd_entry.rdata = '0;
        if (icb_cmd_read && !cmd_err) cmd_entry.rdata = mem_q[word_idx];
    end

    always_ff @(posedge clk) begin
        if (accept && !icb_cmd_read && !cmd_err) begin
            for (int i = 0; i < NB; i++) begin
                if (icb_cmd_wmask[i]) mem_q[word_idx][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
            end
        end
    end

    // The FIFO register is the last latency stage, hence only LAT-1 pipe stages.
    if (LAT == 1) begin : g_no_pipe
        assign fifo_push = accept;
        assign fifo_din  = cmd_entry;
    end else begin : g_pipe
        logic [LAT-2:0] vld_q;
        rsp_entry_t     ent_q [LAT-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= accept;
                for (int i = 1; i < LAT - 1; i++) vld_q[i] <= vld_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            ent_q[0] <= cmd_entry;
            for (int i = 1; i < LAT - 1; i++) ent_q[i] <= ent_q[i-1];
        end

        assign fifo_push = vld_q[LAT-2];
        assign fifo_din  = ent_q[LAT-2];
    end

    e203_icb_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (rsp_xfer),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign icb_rsp_valid = ~fifo_empty;
    assign icb_rsp_err   = icb_rsp_valid & fifo_dout.err;
    assign icb_rsp_rdata = icb_rsp_valid ? fifo_dout.rdata : '0;

    no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                       !(fifo_push && fifo_full));

endmodule

// File: tb/tb_e203_icb_mem_slave.sv
// Scoreboard bench for e203_icb_mem_slave (LAT=1, RSP_DEPTH=2): a reference memory
// model predicts each response at accept time; responses are compared in order.
module tb_e203_icb_mem_slave;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } expT;

    logic        clk;
    logic        rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;

    int          compareCnt;
    int          mismatchCnt;
    int          rspCnt;
    int          rspBefore;
    expT         expQ [$];
    expT         monE;
    expT         gotE;
    logic [31:0] memModel [1024];
    logic [9:0]  monIdx;

    e203_icb_mem_slave #(
        .AW        (32),
        .DW        (32),
        .MEM_AW    (10),
        .BASE_ADDR (32'h1000_0000),
        .LAT       (1),
        .RSP_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_err   (icb_rsp_err),
        .icb_rsp_rdata (icb_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCnt++;
        if (obs !== exp) begin
            mismatchCnt++;
            $display("[TB] FAIL %s: got %h, expected %h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic modelErr(input logic [31:0] a);
        return (a[31:12] != 20'h10000) || (a[1:0] != 2'b00);
    endfunction

    // Prediction at accept, comparison at response transfer.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (icb_cmd_valid && icb_cmd_ready) begin
                monIdx     = icb_cmd_addr[11:2];
                monE.err   = modelErr(icb_cmd_addr);
                monE.rdata = 32'h0;
                if (!monE.err) begin
                    if (icb_cmd_read) begin
                        monE.rdata = memModel[monIdx];
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (icb_cmd_wmask[b]) memModel[monIdx][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
                    end
                end
                expQ.push_back(monE);
            end
            if (icb_rsp_valid && icb_rsp_ready) begin
                rspCnt++;
                if (expQ.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'(expQ.size()), 32'd1);
                end else begin
                    gotE = expQ.pop_front();
                    checkOutput("rsp_err", {31'd0, icb_rsp_err}, {31'd0, gotE.err});
                    checkOutput("rsp_rdata", icb_rsp_rdata, gotE.rdata);
                end
            end
        end
    end

    // Called one delta past a rising edge; returns one delta past the accepting edge.
    task automatic applyStimulus(input logic rd, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] mask);
        int waitCnt;
        waitCnt       = 0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = addr;
        icb_cmd_wdata = data;
        icb_cmd_wmask = mask;
        @(negedge clk);
        while (!icb_cmd_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!icb_cmd_ready) checkOutput("cmd_accept_timeout", {31'd0, icb_cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        icb_cmd_valid = 1'b0;
    endtask

    task automatic drainWait();
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        while ((icb_rsp_valid || expQ.size() != 0) && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (icb_rsp_valid || expQ.size() != 0)
            checkOutput("drain_timeout", {31'd0, icb_rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        compareCnt    = 0;
        mismatchCnt   = 0;
        rspCnt        = 0;
        rst_n         = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = 32'h0;
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'h0;
        icb_rsp_ready = 1'b1;

        #2;
        checkOutput("reset_rsp_valid", {31'd0, icb_rsp_valid}, 32'd0);
        checkOutput("reset_rsp_err", {31'd0, icb_rsp_err}, 32'd0);
        checkOutput("reset_rsp_rdata", icb_rsp_rdata, 32'd0);
        checkOutput("reset_cmd_ready", {31'd0, icb_cmd_ready}, 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full write then read-back at minimum latency
        applyStimulus(1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
        applyStimulus(1'b1, 32'h1000_0010, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("read_latency_valid", {31'd0, icb_rsp_valid}, 32'd1);
        checkOutput("read_rdata_direct", icb_rsp_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

        // Partial write and zero-mask write
        applyStimulus(1'b0, 32'h1000_0020, 32'hFFFF_FFFF, 4'hF);
        applyStimulus(1'b0, 32'h1000_0020, 32'h1122_3344, 4'b0101);
        applyStimulus(1'b1, 32'h1000_0020, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("partial_rdata", icb_rsp_rdata, 32'hFF22_FF44);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h1000_0020, 32'h0000_0000, 4'h0);
        @(negedge clk);
        checkOutput("wmask0_err", {31'd0, icb_rsp_err}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h1000_0020, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("wmask0_rdata", icb_rsp_rdata, 32'hFF22_FF44);
        @(posedge clk);
        #1;

        // Error accesses must not touch memory
        applyStimulus(1'b1, 32'h2000_0000, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("oob_err", {31'd0, icb_rsp_err}, 32'd1);
        checkOutput("oob_rdata", icb_rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h1000_0002, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("misalign_err", {31'd0, icb_rsp_err}, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h1000_0012, 32'h0BAD_0BAD, 4'hF);
        applyStimulus(1'b0, 32'h3000_0010, 32'h0BAD_0BAD, 4'hF);
        applyStimulus(1'b1, 32'h1000_0010, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("err_no_corrupt", icb_rsp_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        drainWait();

        // Back-pressure: RSP_DEPTH bounds outstanding commands
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = 32'h1000_0010;
        @(negedge clk);
        checkOutput("bp_ready_a", {31'd0, icb_cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        icb_cmd_addr = 32'h1000_0020;
        @(negedge clk);
        checkOutput("bp_ready_b", {31'd0, icb_cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        icb_cmd_addr = 32'h1000_0010;
        @(negedge clk);
        checkOutput("bp_ready_c", {31'd0, icb_cmd_ready}, 32'd0);
        checkOutput("bp_head_rdata", icb_rsp_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("bp_hold_ready", {31'd0, icb_cmd_ready}, 32'd0);
        checkOutput("bp_hold_rdata", icb_rsp_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        icb_rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_no_comb_path", {31'd0, icb_cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("bp_ready_after_xfer", {31'd0, icb_cmd_ready}, 32'd1);
        checkOutput("bp_second_rdata", icb_rsp_rdata, 32'hFF22_FF44);
        @(posedge clk);
        #1;
        icb_cmd_valid = 1'b0;
        drainWait();

        // Back-to-back reads with rsp_ready held high
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b0, 32'h1000_0100 + 32'(i * 4), 32'hA500_0000 ^ 32'(i * 32'h0001_0203), 4'hF);
        drainWait();
        rspBefore = rspCnt;
        for (int i = 0; i < 16; i++) begin
            icb_cmd_valid = 1'b1;
            icb_cmd_read  = 1'b1;
            icb_cmd_addr  = 32'h1000_0100 + 32'(i * 4);
            @(negedge clk);
            checkOutput("b2b_ready", {31'd0, icb_cmd_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        icb_cmd_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("b2b_rsp_count", 32'(rspCnt - rspBefore), 32'd16);
        drainWait();

        // Asynchronous reset with responses queued
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = 32'h1000_0010;
        @(negedge clk);
        @(posedge clk);
        #1;
        icb_cmd_addr = 32'h1000_0020;
        @(negedge clk);
        @(posedge clk);
        #1;
        icb_cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_valid", {31'd0, icb_rsp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_async_valid", {31'd0, icb_rsp_valid}, 32'd0);
        checkOutput("reset_async_cmd_ready", {31'd0, icb_cmd_ready}, 32'd1);
        expQ.delete();
        icb_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("post_reset_cmd_ready", {31'd0, icb_cmd_ready}, 32'd1);
        checkOutput("post_reset_valid", {31'd0, icb_rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h1000_0010, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("post_reset_rdata", icb_rsp_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        drainWait();
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
        $finish;
    end

endmodule
